// File: rtl/parity_pkg.sv
// Shared types and constants for the XOR-parity serial link receiver.
package parity_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_e;

  localparam int ERR_CNT_MAX = 255;

  // Odd parity seeds the accumulator with 1 so a correct frame always ends at 0.
  function automatic logic par_init(input logic odd);
    return odd;
  endfunction

endpackage

// File: rtl/parity_accum.sv
// 1-bit XOR parity accumulator; receive-side twin of the transmit parity generator.
module parity_accum (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic seed,
  input  logic en,
  input  logic bit_in,
  output logic acc
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    acc <= 1'b0;
    else if (load) acc <= seed;
    else if (en)   acc <= acc ^ bit_in;
  end

endmodule

// File: rtl/serial_parity_checker.sv
// Deserialises start / DATA_W bits LSB first / parity / stop frames and reports
// the word with parity and framing status plus a saturating error count.
module serial_parity_checker
  import parity_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter bit ODD_PARITY = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              bit_in,
  input  logic              bit_valid,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              parity_err,
  output logic              frame_err,
  output logic              busy,
  output logic [7:0]        err_cnt
);

  localparam int CW = $clog2(DATA_W + 1);

  state_e            state, state_nxt;
  logic [CW-1:0]     cnt;
  logic [DATA_W-1:0] shreg, sh_nxt;
  logic              acc, acc_load, acc_en, done, last;

  // First bit received must land in bit 0, so bits enter at the MSB.
  generate
    if (DATA_W == 1) begin : g_sh1
      assign sh_nxt = bit_in;
    end else begin : g_shn
      assign sh_nxt = {bit_in, shreg[DATA_W-1:1]};
    end
  endgenerate

  assign last = (cnt == CW'(DATA_W - 1));
  assign busy = (state != IDLE);

  always_comb begin
    state_nxt = state;
    acc_load  = 1'b0;
    acc_en    = 1'b0;
    done      = 1'b0;
    if (bit_valid) begin
      case (state)
        IDLE: if (!bit_in) begin
          state_nxt = DATA;
          acc_load  = 1'b1;
        end
        DATA: begin
          acc_en = 1'b1;
          if (last) state_nxt = PARITY;
        end
        PARITY: begin
          acc_en    = 1'b1;
          state_nxt = STOP;
        end
        STOP: begin
          // A 0 stop bit is a framing error, never a new start bit.
          done      = 1'b1;
          state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      shreg <= '0;
    end else begin
      state <= state_nxt;
      if (bit_valid && state == IDLE && !bit_in) cnt <= '0;
      if (bit_valid && state == DATA) begin
        cnt   <= cnt + CW'(1);
        shreg <= sh_nxt;
      end
    end
  end

  parity_accum u_accum (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (acc_load),
    .seed   (par_init(ODD_PARITY)),
    .en     (acc_en),
    .bit_in (bit_in),
    .acc    (acc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out   <= '0;
      data_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      err_cnt    <= '0;
    end else begin
      data_valid <= done;
      if (done) begin
        data_out   <= shreg;
        parity_err <= acc;
        frame_err  <= ~bit_in;
        if ((acc || !bit_in) && err_cnt != 8'(ERR_CNT_MAX))
          err_cnt <= err_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_serial_parity_checker.sv
// Random and directed frames into even- and odd-parity receivers, scored against a frame-level model.
module tb_serial_parity_checker;

  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          bit_in = 1'b1;
  logic          bit_valid = 1'b0;
  logic [DW-1:0] dout_e, dout_o;
  logic          dv_e, dv_o, pe_e, pe_o, fe_e, fe_o, busy_e, busy_o;
  logic [7:0]    ec_e, ec_o;

  always #5 clk = ~clk;

  serial_parity_checker #(.DATA_W(DW), .ODD_PARITY(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .bit_in(bit_in), .bit_valid(bit_valid),
    .data_out(dout_e), .data_valid(dv_e), .parity_err(pe_e), .frame_err(fe_e),
    .busy(busy_e), .err_cnt(ec_e));

  serial_parity_checker #(.DATA_W(DW), .ODD_PARITY(1'b1)) dut_odd (
    .clk(clk), .rst_n(rst_n), .bit_in(bit_in), .bit_valid(bit_valid),
    .data_out(dout_o), .data_valid(dv_o), .parity_err(pe_o), .frame_err(fe_o),
    .busy(busy_o), .err_cnt(ec_o));

  typedef struct {
    logic [DW-1:0] d;
    logic          pe, po, fe;
    int            ce, co;
    int            due;
  } exp_t;

  exp_t q[$];
  int   checks = 0, errors = 0;
  int   cyc = 0, pulses = 0, frames = 0;
  int   cnt_e = 0, cnt_o = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Frame results are due one cycle after the stop bit is accepted.
  always @(negedge clk) begin
    if (dv_e) pulses++;
    if (q.size() > 0 && q[0].due == cyc) begin
      exp_t e;
      e = q.pop_front();
      chk("dv_e", dv_e, 1);
      chk("dv_o", dv_o, 1);
      chk("data_e", dout_e, e.d);
      chk("data_o", dout_o, e.d);
      chk("perr_e", pe_e, e.pe);
      chk("perr_o", pe_o, e.po);
      chk("ferr_e", fe_e, e.fe);
      chk("ferr_o", fe_o, e.fe);
      chk("ecnt_e", ec_e, e.ce);
      chk("ecnt_o", ec_o, e.co);
      chk("busy_done", busy_e, 0);
    end else if (dv_e || dv_o) begin
      chk("spurious_dv", {dv_e, dv_o}, 0);
    end
  end

  task automatic send_bit(input logic b, input int maxgap);
    int gap;
    gap = (maxgap > 0) ? $urandom_range(maxgap, 0) : 0;
    repeat (gap) begin
      @(negedge clk);
      bit_valid = 1'b0;
      bit_in    = 1'($urandom);
    end
    @(negedge clk);
    bit_valid = 1'b1;
    bit_in    = b;
  endtask

  task automatic quiet(input int n);
    repeat (n) begin
      @(negedge clk);
      bit_valid = 1'b0;
    end
  endtask

  task automatic send_frame(input logic [DW-1:0] d, input logic p, input logic s, input int maxgap);
    exp_t e;
    send_bit(1'b0, maxgap);
    for (int i = 0; i < DW; i++) send_bit(d[i], maxgap);
    send_bit(p, maxgap);
    send_bit(s, maxgap);
    e.d   = d;
    e.pe  = (^d) ^ p;
    e.po  = ~((^d) ^ p);
    e.fe  = ~s;
    if ((e.pe || e.fe) && cnt_e < 255) cnt_e++;
    if ((e.po || e.fe) && cnt_o < 255) cnt_o++;
    e.ce  = cnt_e;
    e.co  = cnt_o;
    e.due = cyc + 1;
    q.push_back(e);
    frames++;
  endtask

  initial begin
    int p0;
    logic [DW-1:0] d;
    #1;
    chk("rst_data", dout_e, 0);
    chk("rst_dv", dv_e, 0);
    chk("rst_busy", busy_e, 0);
    chk("rst_ecnt", ec_e, 0);
    chk("rst_perr_ferr", {pe_e, fe_e}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Idle line, then the reference frames.
    repeat (3) send_bit(1'b1, 0);
    send_frame(8'hA5, 1'b0, 1'b1, 0);
    send_frame(8'hA5, 1'b1, 1'b1, 0);
    send_frame(8'h3C, 1'b0, 1'b0, 0);
    send_bit(1'b1, 0);
    send_frame(8'h01, 1'b1, 1'b1, 0);
    send_frame(8'hA5, 1'b0, 1'b1, 3);
    quiet(3);

    // Abort mid-frame with an asynchronous reset.
    send_bit(1'b0, 0);
    for (int i = 0; i < 4; i++) send_bit(1'($urandom), 0);
    @(negedge clk);
    bit_valid = 1'b0;
    chk("busy_mid", busy_e, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_data", dout_e, 0);
    chk("abort_ecnt", {ec_e, ec_o}, 0);
    chk("abort_busy", {busy_e, busy_o}, 0);
    chk("abort_flags", {dv_e, pe_e, fe_e}, 0);
    cnt_e = 0;
    cnt_o = 0;
    @(negedge clk);
    rst_n = 1'b1;
    send_frame(8'h5A, 1'b0, 1'b1, 0);
    quiet(2);

    // Random frames, gaps, idle bits and errors.
    for (int n = 0; n < 40; n++) begin
      d = 8'($urandom);
      if ($urandom_range(3, 0) == 0) send_bit(1'b1, 2);
      send_frame(d, (^d) ^ ($urandom_range(3, 0) == 0),
                 ($urandom_range(4, 0) != 0), $urandom_range(3, 0));
    end
    quiet(3);

    // Back-to-back bad even parity to saturate the error counter.
    p0 = pulses;
    for (int n = 0; n < 260; n++) begin
      d = 8'($urandom);
      send_frame(d, ~(^d), 1'b1, 0);
    end
    quiet(4);
    chk("sat_pulses", pulses - p0, 260);
    chk("sat_ecnt", ec_e, 255);
    chk("queue_empty", q.size(), 0);
    chk("total_pulses", pulses, frames);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
